obi_spi_bus_guard: RTL and testbench

//  Register slice + address-window guard between the SPI slave's OBI master port and the system OBI bus.

---
 rtl/obi_spi_bus_guard_if.sv | 16 +
 rtl/obi_spi_bus_guard.sv | 91 +++++++++
 tb/tb_obi_spi_bus_guard.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/obi_spi_bus_guard_if.sv
// obi_spi_bus_guard_if: OBI request/response bundle with master and slave views
interface obi_spi_bus_guard_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          gnt;
   logic [AW-1:0] addr;
   logic          we;
   logic [DW-1:0] wdata;
   logic [3:0]    be;
   logic          rvalid;
   logic [DW-1:0] rdata;
   modport master (output req, addr, we, wdata, be, input gnt, rvalid, rdata);
   modport slave (input req, addr, we, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_spi_bus_guard.sv
// obi_spi_bus_guard: OBI register slice with outstanding limit and address-window guard
module obi_spi_bus_guard #(
   parameter int                          OBI_ADDR_WIDTH  = 32,
   parameter int                          OBI_DATA_WIDTH  = 32,
   parameter int                          MAX_OUTSTANDING = 2,
   parameter logic [OBI_ADDR_WIDTH-1:0]   WIN_BASE        = '0,
   parameter logic [OBI_ADDR_WIDTH-1:0]   WIN_SIZE        = '0,
   parameter logic [OBI_DATA_WIDTH-1:0]   ERR_RDATA       = 'hBADC_AB1E,
   localparam int                         OW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                      obi_aclk,
   input  logic                      obi_aresetn,
   obi_spi_bus_guard_if.slave        s,
   obi_spi_bus_guard_if.master       m,
   output logic                      err_pulse,
   output logic [OBI_ADDR_WIDTH-1:0] err_addr,
   output logic [7:0]                err_count,
   output logic [OW-1:0]             outstanding
);
   logic          slot_full;
   logic          in_window;
   logic          accept;
   logic          fwd_accept;
   logic          blk_accept;
   logic          rsp_ok;
   logic [OW-1:0] fwd_cnt;

   // A blocked access is only admitted once everything ahead of it has responded, which keeps responses in order.
   assign in_window  = (WIN_SIZE == '0) || ((s.addr - WIN_BASE) < WIN_SIZE);
   assign s.gnt      = ~slot_full & (outstanding < OW'(MAX_OUTSTANDING)) & (in_window | (outstanding == '0));
   assign accept     = s.req & s.gnt;
   assign fwd_accept = accept & in_window;
   assign blk_accept = accept & ~in_window;
   assign rsp_ok     = m.rvalid & (fwd_cnt != '0);
   assign m.req      = slot_full;

   // Request slot: loads on an in-window accept, holds the fields until the bus grants.
   always_ff @(posedge obi_aclk or negedge obi_aresetn)
      if (!obi_aresetn) begin
         slot_full <= 1'b0;
         m.addr    <= '0;
         m.we      <= 1'b0;
         m.wdata   <= '0;
         m.be      <= '0;
      end else if (fwd_accept) begin
         slot_full <= 1'b1;
         m.addr    <= s.addr;
         m.we      <= s.we;
         m.wdata   <= s.wdata;
         m.be      <= s.be;
      end else if (m.gnt) begin
         slot_full <= 1'b0;
      end

   // Transaction counters: all accepted-but-unresponded, and the forwarded subset the bus still owes.
   always_ff @(posedge obi_aclk or negedge obi_aresetn)
      if (!obi_aresetn) begin
         outstanding <= '0;
         fwd_cnt     <= '0;
      end else begin
         outstanding <= outstanding + OW'(accept) - OW'(s.rvalid);
         fwd_cnt     <= fwd_cnt + OW'(fwd_accept) - OW'(rsp_ok);
      end

   // Response register: bus responses pass through one stage, blocked accesses answer locally with the error word.
   always_ff @(posedge obi_aclk or negedge obi_aresetn)
      if (!obi_aresetn) begin
         s.rvalid  <= 1'b0;
         s.rdata   <= '0;
         err_pulse <= 1'b0;
      end else begin
         s.rvalid  <= rsp_ok | blk_accept;
         err_pulse <= blk_accept;
         if (rsp_ok | blk_accept) s.rdata <= blk_accept ? ERR_RDATA : m.rdata;
      end

   // Error log: last blocked address and a saturating count of blocked accesses.
   always_ff @(posedge obi_aclk or negedge obi_aresetn)
      if (!obi_aresetn) begin
         err_addr  <= '0;
         err_count <= '0;
      end else if (blk_accept) begin
         err_addr  <= s.addr;
         err_count <= err_count + 8'(err_count != 8'hFF);
      end

   stray_rvalid: assert property (@(posedge obi_aclk) disable iff (!obi_aresetn) m.rvalid |-> fwd_cnt != '0)
      else $warning("stray m_rvalid ignored");
   max_outstanding: assert property (@(posedge obi_aclk) disable iff (!obi_aresetn) outstanding <= OW'(MAX_OUTSTANDING));
   rsp_has_txn: assert property (@(posedge obi_aclk) disable iff (!obi_aresetn) s.rvalid |-> outstanding != '0);
endmodule

// File: tb/tb_obi_spi_bus_guard.sv
// tb_obi_spi_bus_guard: directed and random stimulus against a transaction-level reference model
module tb_obi_spi_bus_guard;
   localparam logic [31:0] WB   = 32'h1000_0000;
   localparam logic [31:0] WS   = 32'h0001_0000;
   localparam logic [31:0] ERR  = 32'hBADC_AB1E;
   localparam int          MAXO = 2;
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;
   logic        obi_aclk = 1'b0;
   logic        obi_aresetn = 1'b0;
   logic        err_pulse;
   logic [31:0] err_addr;
   logic [7:0]  err_count;
   logic [1:0]  outstanding;
   int          checks = 0;
   int          errors = 0;
   int          n_out;
   bit          pend_v;
   txn_t        pend;
   txn_t        bus_q[$];
   bit          rsp_v;
   logic [31:0] rsp_d;
   bit          err_p;
   logic [31:0] e_addr;
   int          e_cnt;

   obi_spi_bus_guard_if #(.AW(32), .DW(32)) sif();
   obi_spi_bus_guard_if #(.AW(32), .DW(32)) mif();

   obi_spi_bus_guard #(
      .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO),
      .WIN_BASE(WB), .WIN_SIZE(WS), .ERR_RDATA(ERR)
   ) dut (
      .obi_aclk(obi_aclk), .obi_aresetn(obi_aresetn), .s(sif), .m(mif),
      .err_pulse(err_pulse), .err_addr(err_addr), .err_count(err_count), .outstanding(outstanding)
   );

   always #5 obi_aclk = ~obi_aclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a - WB) < WS;
   endfunction

   function automatic void model_clear();
      n_out = 0;
      pend_v = 0;
      bus_q.delete();
      rsp_v = 0;
      rsp_d = '0;
      err_p = 0;
      e_addr = '0;
      e_cnt = 0;
   endfunction

   // One clock: drive inputs, compare every output with the model, advance the model, wait for the edge.
   task automatic cyc(input bit req, input logic [31:0] a, input bit we, input logic [31:0] wd,
                      input logic [3:0] be, input bit gnt, input bit rv, input logic [31:0] rd);
      bit exp_gnt, acc, inw, fwd_rv;
      sif.req = req; sif.addr = a; sif.we = we; sif.wdata = wd; sif.be = be;
      mif.gnt = gnt; mif.rvalid = rv; mif.rdata = rd;
      #1;
      inw = in_win(a);
      exp_gnt = !pend_v && n_out < MAXO && (inw || n_out == 0);
      chk("s_gnt", 32'(sif.gnt), 32'(exp_gnt));
      chk("m_req", 32'(mif.req), 32'(pend_v));
      if (pend_v) begin
         chk("m_addr", mif.addr, pend.addr);
         chk("m_we", 32'(mif.we), 32'(pend.we));
         chk("m_wdata", mif.wdata, pend.wdata);
         chk("m_be", 32'(mif.be), 32'(pend.be));
      end
      chk("s_rvalid", 32'(sif.rvalid), 32'(rsp_v));
      if (rsp_v) chk("s_rdata", sif.rdata, rsp_d);
      chk("err_pulse", 32'(err_pulse), 32'(err_p));
      chk("err_addr", err_addr, e_addr);
      chk("err_count", 32'(err_count), 32'(e_cnt));
      chk("outstanding", 32'(outstanding), 32'(n_out));
      if (obi_aresetn) begin
         acc = req && exp_gnt;
         fwd_rv = rv && bus_q.size() > 0;
         n_out = n_out + int'(acc) - int'(rsp_v);
         if (fwd_rv) void'(bus_q.pop_front());
         if (pend_v && gnt) begin
            bus_q.push_back(pend);
            pend_v = 0;
         end
         rsp_v = fwd_rv || (acc && !inw);
         rsp_d = fwd_rv ? rd : ERR;
         err_p = acc && !inw;
         if (err_p) begin
            e_addr = a;
            if (e_cnt < 255) e_cnt++;
         end
         if (acc && inw) begin
            pend_v = 1;
            pend = '{a, we, wd, be};
         end
      end
      @(posedge obi_aclk);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) cyc(0, '0, 0, '0, '0, 1, bus_q.size() > 0, $urandom);
   endtask

   initial begin
      sif.req = 0; sif.addr = '0; sif.we = 0; sif.wdata = '0; sif.be = '0;
      mif.gnt = 0; mif.rvalid = 0; mif.rdata = '0;
      model_clear();
      @(posedge obi_aclk);
      #1;
      cyc(1, 32'h4000_0000, 0, '0, '0, 0, 0, '0);
      cyc(1, WB + 32'h10, 1, 32'h1234_5678, 4'hF, 1, 1, '0);
      chk("rst_s_gnt", 32'(sif.gnt), 32'd1);
      chk("rst_m_req", 32'(mif.req), 32'd0);
      obi_aresetn = 1;
      cyc(1, 32'h1000_0040, 1, 32'hCAFE_F00D, 4'hF, 0, 0, '0);
      chk("t2_m_req", 32'(mif.req), 32'd1);
      chk("t2_m_addr", mif.addr, 32'h1000_0040);
      chk("t2_m_wdata", mif.wdata, 32'hCAFE_F00D);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      cyc(0, '0, 0, '0, '0, 1, 0, '0);
      cyc(0, '0, 0, '0, '0, 0, 1, 32'h0);
      chk("t2_s_rvalid", 32'(sif.rvalid), 32'd1);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      chk("t2_outstanding", 32'(outstanding), 32'd0);
      cyc(1, 32'h4000_0000, 0, '0, '0, 0, 0, '0);
      chk("t3_s_rvalid", 32'(sif.rvalid), 32'd1);
      chk("t3_s_rdata", sif.rdata, 32'hBADC_AB1E);
      chk("t3_err_pulse", 32'(err_pulse), 32'd1);
      chk("t3_err_addr", err_addr, 32'h4000_0000);
      chk("t3_err_count", 32'(err_count), 32'd1);
      chk("t3_m_req", 32'(mif.req), 32'd0);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      cyc(1, WB + 32'h100, 0, '0, '0, 1, 0, '0);
      repeat (6) cyc(1, WB + 32'h104, 0, '0, '0, 1, 0, '0);
      chk("t4_outstanding", 32'(outstanding), 32'd2);
      chk("t4_s_gnt", 32'(sif.gnt), 32'd0);
      cyc(1, WB + 32'h104, 0, '0, '0, 1, 1, 32'h1111_2222);
      chk("t4_s_rvalid", 32'(sif.rvalid), 32'd1);
      chk("t4_s_rdata", sif.rdata, 32'h1111_2222);
      repeat (3) cyc(1, WB + 32'h104, 0, '0, '0, 1, 0, '0);
      drain(8);
      cyc(1, WB + 32'h200, 0, '0, '0, 1, 0, '0);
      repeat (4) cyc(1, 32'h8000_0000, 0, '0, '0, 1, 0, '0);
      chk("t5_s_gnt", 32'(sif.gnt), 32'd0);
      cyc(1, 32'h8000_0000, 0, '0, '0, 1, 1, 32'h5555_AAAA);
      chk("t5_s_rdata", sif.rdata, 32'h5555_AAAA);
      chk("t5_err_pulse", 32'(err_pulse), 32'd0);
      repeat (2) cyc(1, 32'h8000_0000, 0, '0, '0, 1, 0, '0);
      chk("t5_err_pulse2", 32'(err_pulse), 32'd1);
      chk("t5_s_rdata2", sif.rdata, ERR);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      cyc(1, WB + 32'h300, 0, '0, '0, 0, 0, '0);
      cyc(0, '0, 0, '0, '0, 1, 0, '0);
      cyc(1, WB + 32'h304, 0, '0, '0, 0, 0, '0);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      chk("t6_m_req", 32'(mif.req), 32'd1);
      chk("t6_outstanding", 32'(outstanding), 32'd2);
      obi_aresetn = 0;
      #1;
      chk("t6_rst_m_req", 32'(mif.req), 32'd0);
      chk("t6_rst_outstanding", 32'(outstanding), 32'd0);
      chk("t6_rst_err_count", 32'(err_count), 32'd0);
      chk("t6_rst_err_addr", err_addr, 32'd0);
      model_clear();
      repeat (2) cyc(0, '0, 0, '0, '0, 0, 0, '0);
      obi_aresetn = 1;
      cyc(0, '0, 0, '0, '0, 0, 1, 32'hDEAD_0001);
      chk("t6_stray", 32'(sif.rvalid), 32'd0);
      cyc(0, '0, 0, '0, '0, 0, 0, '0);
      repeat (600) cyc(1, 32'hF000_0000 | ($urandom & 32'hFFFC), 1'($urandom), $urandom, 4'($urandom), 0, 0, '0);
      chk("t6_err_sat", 32'(err_count), 32'd255);
      repeat (2000) cyc($urandom_range(0, 9) < 7,
                        $urandom_range(0, 3) != 0 ? WB + ($urandom & 32'hFFFC) : $urandom,
                        1'($urandom), $urandom, 4'($urandom), 1'($urandom),
                        bus_q.size() > 0 && $urandom_range(0, 2) == 0, $urandom);
      drain(10);
      chk("end_outstanding", 32'(outstanding), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
